// File: rtl/prbs_err_accumulator_pkg.sv
// Shared types and constants for the PRBS error/total-bit accumulator.
package prbs_err_accumulator_pkg;

    localparam int unsigned Ncnt = 64;

    localparam logic [1:0] MODE_CLEAR  = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_RUN    = 2'd2;
    localparam logic [1:0] MODE_FREEZE = 2'd3;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_SNAP,
        S_FROZEN
    } acc_state_t;

endpackage

// File: rtl/prbs_err_accumulator_if.sv
// JTAG control/readback and PRBS checker flag bundle for the accumulator.
interface prbs_err_accumulator_if #(
    parameter int unsigned Nti = 16
);
    logic [1:0]     prbs_checker_mode;
    logic [Nti-1:0] lane_mask;
    logic           err_valid;
    logic [Nti-1:0] err_signals;
    logic [31:0]    prbs_err_bits_upper;
    logic [31:0]    prbs_err_bits_lower;
    logic [31:0]    prbs_total_bits_upper;
    logic [31:0]    prbs_total_bits_lower;
    logic           snap_valid;
    logic           cnt_sat;

    modport master (
        output prbs_checker_mode, lane_mask, err_valid, err_signals,
        input  prbs_err_bits_upper, prbs_err_bits_lower,
               prbs_total_bits_upper, prbs_total_bits_lower, snap_valid, cnt_sat
    );

    modport slave (
        input  prbs_checker_mode, lane_mask, err_valid, err_signals,
        output prbs_err_bits_upper, prbs_err_bits_lower,
               prbs_total_bits_upper, prbs_total_bits_lower, snap_valid, cnt_sat
    );
endinterface

// File: rtl/prbs_err_accumulator_lane_popcount.sv
// Combinational population count of N lane flags.
module lane_popcount #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]             bits,
    output logic [$clog2(N+1)-1:0]   count_c
);
    localparam int unsigned W = $clog2(N + 1);

    always_comb begin
        count_c = '0;
        for (int i = 0; i < N; i++) begin
            count_c = count_c + W'(bits[i]);
        end
    end
endmodule

// File: rtl/prbs_err_accumulator.sv
// Accumulates masked PRBS error/total bit counts into saturating counters and
// publishes coherent 64-bit snapshots to the JTAG register file.
module prbs_err_accumulator #(
    parameter int unsigned Nti   = 16,
    parameter int unsigned Ncnt  = prbs_err_accumulator_pkg::Ncnt,
    parameter int unsigned Nsync = 2
) (
    input  logic                   clk_adc,
    input  logic                   rstb,
    prbs_err_accumulator_if.slave  bus
);
    import prbs_err_accumulator_pkg::*;

    localparam int unsigned PW = $clog2(Nti + 1);

    logic [1:0]      mode_sync [Nsync];
    logic [Nti-1:0]  mask_sync [Nsync];
    logic [1:0]      msync;
    logic [Nti-1:0]  mask_s;

    acc_state_t      state, next_state;
    logic            accept_c, clear_c, snap_c;

    logic [PW-1:0]   pe_c, pt_c, pe_q, pt_q;
    logic            v1_q;
    logic [Ncnt-1:0] err_acc, tot_acc;
    logic [Ncnt:0]   err_sum_c, tot_sum_c;

    // JTAG-domain mode and mask crossing into the ADC clock
    always_ff @(posedge clk_adc or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < Nsync; i++) begin
                mode_sync[i] <= '0;
                mask_sync[i] <= '0;
            end
        end else begin
            mode_sync[0] <= bus.prbs_checker_mode;
            mask_sync[0] <= bus.lane_mask;
            for (int i = 1; i < Nsync; i++) begin
                mode_sync[i] <= mode_sync[i-1];
                mask_sync[i] <= mask_sync[i-1];
            end
        end
    end

    assign msync  = mode_sync[Nsync-1];
    assign mask_s = mask_sync[Nsync-1];

    always_ff @(posedge clk_adc or negedge rstb) begin
        if (!rstb) state <= S_CLEAR;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_CLEAR, S_HOLD, S_RUN: begin
                if      (msync == MODE_CLEAR)  next_state = S_CLEAR;
                else if (msync == MODE_HOLD)   next_state = S_HOLD;
                else if (msync == MODE_RUN)    next_state = S_RUN;
                else                           next_state = S_DRAIN;
            end
            S_DRAIN:  next_state = (msync == MODE_CLEAR) ? S_CLEAR : S_SNAP;
            S_SNAP:   next_state = S_FROZEN;
            S_FROZEN: begin
                if      (msync == MODE_CLEAR) next_state = S_CLEAR;
                else if (msync == MODE_HOLD)  next_state = S_HOLD;
                else if (msync == MODE_RUN)   next_state = S_RUN;
                else                          next_state = S_FROZEN;
            end
            default:  next_state = S_CLEAR;
        endcase
    end

    always_comb begin
        accept_c = 1'b0;
        clear_c  = 1'b0;
        snap_c   = 1'b0;
        case (state)
            S_CLEAR: clear_c  = 1'b1;
            S_RUN:   accept_c = 1'b1;
            S_SNAP:  snap_c   = 1'b1;
            default: ;
        endcase
    end

    lane_popcount #(.N(Nti)) u_pop_err (.bits(bus.err_signals & mask_s), .count_c(pe_c));
    lane_popcount #(.N(Nti)) u_pop_tot (.bits(mask_s),                   .count_c(pt_c));

    // P1: register lane counts and the acceptance qualifier
    always_ff @(posedge clk_adc or negedge rstb) begin
        if (!rstb) begin
            pe_q <= '0;
            pt_q <= '0;
            v1_q <= 1'b0;
        end else begin
            pe_q <= pe_c;
            pt_q <= pt_c;
            v1_q <= bus.err_valid & accept_c;
        end
    end

    // One extra MSB catches the carry out so the counters clamp instead of wrapping
    assign err_sum_c = {1'b0, err_acc} + (Ncnt+1)'(pe_q);
    assign tot_sum_c = {1'b0, tot_acc} + (Ncnt+1)'(pt_q);

    // P2: saturating accumulate; clear wins over any in-flight commit
    always_ff @(posedge clk_adc or negedge rstb) begin
        if (!rstb) begin
            err_acc     <= '0;
            tot_acc     <= '0;
            bus.cnt_sat <= 1'b0;
        end else if (clear_c) begin
            err_acc     <= '0;
            tot_acc     <= '0;
            bus.cnt_sat <= 1'b0;
        end else if (v1_q) begin
            err_acc <= err_sum_c[Ncnt] ? '1 : err_sum_c[Ncnt-1:0];
            tot_acc <= tot_sum_c[Ncnt] ? '1 : tot_sum_c[Ncnt-1:0];
            if (err_sum_c[Ncnt] || tot_sum_c[Ncnt]) bus.cnt_sat <= 1'b1;
        end
    end

    // Readback registers only move on a snapshot load or a clear
    always_ff @(posedge clk_adc or negedge rstb) begin
        if (!rstb) begin
            bus.prbs_err_bits_upper   <= '0;
            bus.prbs_err_bits_lower   <= '0;
            bus.prbs_total_bits_upper <= '0;
            bus.prbs_total_bits_lower <= '0;
            bus.snap_valid            <= 1'b0;
        end else begin
            bus.snap_valid <= (next_state == S_FROZEN);
            if (clear_c) begin
                bus.prbs_err_bits_upper   <= '0;
                bus.prbs_err_bits_lower   <= '0;
                bus.prbs_total_bits_upper <= '0;
                bus.prbs_total_bits_lower <= '0;
            end else if (snap_c) begin
                bus.prbs_err_bits_upper   <= err_acc[Ncnt-1 -: 32];
                bus.prbs_err_bits_lower   <= err_acc[31:0];
                bus.prbs_total_bits_upper <= tot_acc[Ncnt-1 -: 32];
                bus.prbs_total_bits_lower <= tot_acc[31:0];
            end
        end
    end
endmodule

// File: tb/tb_prbs_err_accumulator.sv
// Directed bench for prbs_err_accumulator with a count-level reference model.
module tb_prbs_err_accumulator;
    import prbs_err_accumulator_pkg::*;

    localparam int unsigned NTI   = 16;
    localparam int unsigned NSYNC = 2;

    logic clk_adc = 1'b0;
    logic rstb    = 1'b1;
    always #5 clk_adc = ~clk_adc;

    prbs_err_accumulator_if #(.Nti(NTI)) bus ();

    prbs_err_accumulator #(.Nti(NTI), .Ncnt(64), .Nsync(NSYNC)) dut (
        .clk_adc (clk_adc),
        .rstb    (rstb),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: counts of what the bench fed while the DUT was settled in RUN
    logic [63:0] m_err = '0;
    logic [63:0] m_tot = '0;
    bit          m_sat = 1'b0;
    bit          m_run = 1'b0;

    function automatic logic [63:0] sat_add(input logic [63:0] a, input int unsigned b);
        if (a > (~64'd0) - 64'(b)) begin
            m_sat = 1'b1;
            return ~64'd0;
        end
        return a + 64'(b);
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_err();
        return {bus.prbs_err_bits_upper, bus.prbs_err_bits_lower};
    endfunction

    function automatic logic [63:0] dut_tot();
        return {bus.prbs_total_bits_upper, bus.prbs_total_bits_lower};
    endfunction

    // Any published snapshot must match the model
    always @(negedge clk_adc) begin
        if (rstb === 1'b1 && bus.snap_valid === 1'b1) begin
            check64("snap_err_model", dut_err(), m_err);
            check64("snap_tot_model", dut_tot(), m_tot);
            check1 ("snap_sat_model", bus.cnt_sat, m_sat);
        end
    end

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk_adc);
        m_run                 = 1'b0;
        bus.err_valid         = 1'b0;
        bus.err_signals       = '0;
        bus.prbs_checker_mode = m;
        repeat (NSYNC + 2) @(negedge clk_adc);
        m_run = (m == MODE_RUN);
    endtask

    task automatic sample(input logic ev, input logic [15:0] f);
        @(negedge clk_adc);
        bus.err_valid   = ev;
        bus.err_signals = f;
        if (ev && m_run) begin
            m_err = sat_add(m_err, $countones(f & bus.lane_mask));
            m_tot = sat_add(m_tot, $countones(bus.lane_mask));
        end
    endtask

    task automatic freeze();
        int k;
        @(negedge clk_adc);
        m_run                 = 1'b0;
        bus.err_valid         = 1'b0;
        bus.err_signals       = '0;
        bus.prbs_checker_mode = MODE_FREEZE;
        k = 0;
        while (k < int'(NSYNC + 3) && bus.snap_valid !== 1'b1) begin
            @(posedge clk_adc);
            #1;
            k++;
        end
        check1("snap_valid_latency", bus.snap_valid, 1'b1);
        @(negedge clk_adc);
    endtask

    task automatic start_clear(input logic [15:0] mask);
        set_mode(MODE_CLEAR);
        m_err = '0;
        m_tot = '0;
        m_sat = 1'b0;
        bus.lane_mask = mask;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.prbs_checker_mode = MODE_CLEAR;
        bus.lane_mask         = '0;
        bus.err_valid         = 1'b0;
        bus.err_signals       = '0;

        // Clear after reset
        #2 rstb = 1'b0;
        repeat (3) @(negedge clk_adc);
        check64("reset_err", dut_err(), 64'd0);
        check64("reset_tot", dut_tot(), 64'd0);
        rstb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_adc);
            check64("clear_err", dut_err(), 64'd0);
            check64("clear_tot", dut_tot(), 64'd0);
            check1 ("clear_snap_valid", bus.snap_valid, 1'b0);
            check1 ("clear_cnt_sat", bus.cnt_sat, 1'b0);
        end

        // Clean run: 100 cycles x 16 lanes
        start_clear(16'hFFFF);
        set_mode(MODE_RUN);
        for (int i = 0; i < 100; i++) sample(1'b1, 16'h0000);
        freeze();
        check64("clean_tot", dut_tot(), 64'd1600);
        check64("clean_err", dut_err(), 64'd0);
        check1 ("clean_sat", bus.cnt_sat, 1'b0);

        // Counted errors with upper lanes masked off
        start_clear(16'h00FF);
        set_mode(MODE_RUN);
        for (int i = 0; i < 50; i++) sample(1'b1, (i % 10 == 3) ? 16'h0003 : 16'hFF00);
        freeze();
        check64("counted_err", dut_err(), 64'd10);
        check64("counted_tot", dut_tot(), 64'd400);

        // Gated samples plus a HOLD window that must add nothing
        start_clear(16'hFFFF);
        set_mode(MODE_RUN);
        for (int i = 0; i < 40; i++) sample((i % 2) == 0, 16'($urandom));
        set_mode(MODE_HOLD);
        for (int i = 0; i < 10; i++) sample(1'b1, 16'hFFFF);
        freeze();
        check64("gated_tot", dut_tot(), 64'd320);

        // Saturation of the total counter
        start_clear(16'hFFFF);
        set_mode(MODE_HOLD);
        @(negedge clk_adc);
        force dut.tot_acc = 64'hFFFF_FFFF_FFFF_FFEC;
        @(negedge clk_adc);
        release dut.tot_acc;
        m_tot = 64'hFFFF_FFFF_FFFF_FFEC;
        set_mode(MODE_RUN);
        for (int i = 0; i < 3; i++) sample(1'b1, 16'h0000);
        freeze();
        check64("sat_tot_upper", 64'(bus.prbs_total_bits_upper), 64'hFFFF_FFFF);
        check64("sat_tot_lower", 64'(bus.prbs_total_bits_lower), 64'hFFFF_FFFF);
        check1 ("sat_flag", bus.cnt_sat, 1'b1);
        set_mode(MODE_HOLD);
        check1 ("sat_sticky_hold", bus.cnt_sat, 1'b1);
        set_mode(MODE_CLEAR);
        check1 ("sat_cleared", bus.cnt_sat, 1'b0);
        check64("sat_clear_tot", dut_tot(), 64'd0);

        // Freeze, resume without clear, then reset mid-drain
        start_clear(16'hFFFF);
        set_mode(MODE_RUN);
        for (int i = 0; i < 30; i++) sample(1'b1, 16'h0101);
        freeze();
        check64("resume1_err", dut_err(), 64'd60);
        check64("resume1_tot", dut_tot(), 64'd480);
        set_mode(MODE_RUN);
        for (int i = 0; i < 20; i++) sample(1'b1, 16'h000F);
        freeze();
        check64("resume2_err", dut_err(), 64'd140);
        check64("resume2_tot", dut_tot(), 64'd800);
        set_mode(MODE_RUN);
        for (int i = 0; i < 10; i++) sample(1'b1, 16'hFFFF);
        @(negedge clk_adc);
        bus.err_valid         = 1'b0;
        bus.prbs_checker_mode = MODE_FREEZE;
        repeat (NSYNC + 1) @(posedge clk_adc);
        @(negedge clk_adc);
        rstb = 1'b0;
        m_err = '0;
        m_tot = '0;
        m_sat = 1'b0;
        #1;
        check64("abort_err", dut_err(), 64'd0);
        check64("abort_tot", dut_tot(), 64'd0);
        check1 ("abort_snap_valid", bus.snap_valid, 1'b0);
        bus.prbs_checker_mode = MODE_CLEAR;
        @(negedge clk_adc);
        rstb = 1'b1;
        repeat (10) @(negedge clk_adc);
        check64("post_abort_tot", dut_tot(), 64'd0);
        check1 ("post_abort_snap_valid", bus.snap_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
